// File: rtl/mem_stream_pkg.sv
// ---------------------------------------------------------------------------
// mem_stream_pkg
// Shared types and constants for the memory read streamer and its skid FIFO.
//   stream_state_t : transfer FSM states (IDLE, RUN, DRAIN)
//   FIFO_DEPTH     : skid buffer depth; two entries cover one read in flight
//                    plus one beat held while the sink stalls
//   FIFO_CNT_W     : width of the FIFO occupancy count (0..FIFO_DEPTH)
//   FIFO_PTR_W     : width of the FIFO read/write pointers
// ---------------------------------------------------------------------------
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/stream_skid_fifo.sv
// ---------------------------------------------------------------------------
// stream_skid_fifo
// Two-entry FIFO that absorbs beats already launched from the memory while the
// downstream sink is stalled. The head entry drives the read port directly, so
// the presented data stays stable until it is popped.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   push wr_data (ignored when full and not popping)
//   wr_data  in   W-bit entry
//   rd_en    in   pop the head entry when rd_valid
//   rd_valid out  FIFO holds at least one entry
//   rd_data  out  head entry (zero after reset)
//   count    out  number of entries held
// ---------------------------------------------------------------------------
module stream_skid_fifo
    import mem_stream_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [W-1:0]          rd_data,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = {{(FIFO_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_W-1:0] PTR_ONE  = {{(FIFO_PTR_W-1){1'b0}}, 1'b1};

    logic [W-1:0]          store [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_rd;
    logic                  do_wr;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a
    // push when the head is being consumed.
    always_comb begin
        do_rd    = rd_en && (count != '0);
        do_wr    = wr_en && ((count != CNT_FULL) || do_rd);
        rd_valid = (count != '0);
        rd_data  = store[rd_ptr];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                store[wr_ptr] <= wr_data;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_read_streamer.sv
// ---------------------------------------------------------------------------
// mem_read_streamer
// On a start command reads len consecutive words from base_addr (wrapping
// modulo SIZE) out of a single-port memory with a 1-cycle registered read, and
// forwards them as a valid/ready stream with a last marker. Reads are issued
// only when the skid FIFO is guaranteed a free slot for the returning data, so
// no beat is ever lost or duplicated under any m_ready pattern.
//
// Optional feature macro: MEM_STREAM_CHK_EN
//   defined     : chk output carries the XOR of all accepted beats of the
//                 current/last transfer (cleared on an accepted start)
//   not defined : chk port and checksum logic are absent
//
// Ports:
//   clk          in   rising-edge clock, shared with the memory
//   rst_n        in   asynchronous active-low reset
//   start        in   1-cycle command pulse, ignored while busy
//   base_addr    in   first address, sampled with start
//   len          in   word count 0..SIZE, sampled with start
//   mem_we       out  memory write enable, always 0
//   mem_addr     out  memory address
//   mem_rd_data  in   memory read data, valid 1 cycle after mem_addr
//   m_valid      out  stream beat valid
//   m_data       out  stream beat data
//   m_last       out  final beat of the transfer
//   m_ready      in   sink accepts beat when m_valid && m_ready
//   busy         out  transfer in progress
//   done         out  1-cycle pulse when the transfer completes
//   chk          out  XOR checksum (MEM_STREAM_CHK_EN only)
// ---------------------------------------------------------------------------
module mem_read_streamer
    import mem_stream_pkg::*;
#(
    parameter int SIZE   = 256,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic              m_valid,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
`ifdef MEM_STREAM_CHK_EN
    ,
    output logic [WIDTH-1:0]  chk
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    stream_state_t         state;
    stream_state_t         state_nxt;
    logic [ADDR_W:0]       len_q;
    logic [ADDR_W:0]       issued;
    logic [ADDR_W:0]       accepted;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_valid;
    logic [WIDTH:0]        fifo_out;
    logic [FIFO_CNT_W:0]   committed;
    logic [FIFO_CNT_W:0]   credit_limit;
    logic                  start_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  beat_acc;
    logic                  final_acc;

    // Handshake and issue decisions. A slot is committed once a read is
    // issued (in flight) and until its beat is popped; a beat popped this
    // cycle returns its slot immediately, which keeps 1 beat/cycle with
    // m_ready held high.
    always_comb begin
        start_ok     = (state == IDLE) && start;
        beat_acc     = fifo_valid && m_ready;
        final_acc    = beat_acc && (accepted == (len_q - CNT_ONE));
        committed    = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, in_flight};
        credit_limit = (FIFO_CNT_W + 1)'(FIFO_DEPTH) + {{FIFO_CNT_W{1'b0}}, beat_acc};
        issue        = (state == RUN) && (issued < len_q) && (committed < credit_limit);
        issue_last   = issue && (issued == (len_q - CNT_ONE));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: RUN until the final read is issued, DRAIN until the
    // final beat is accepted. A zero-length start never leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (len != '0)) state_nxt = RUN;
            RUN:     if (issue_last)           state_nxt = DRAIN;
            DRAIN:   if (final_acc)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Address, counters and the in-flight tag that marks which cycle's
    // mem_rd_data must be captured into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr       <= '0;
            len_q          <= '0;
            issued         <= '0;
            accepted       <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            done           <= 1'b0;
        end else begin
            done           <= (start_ok && (len == '0)) || final_acc;
            in_flight      <= issue;
            in_flight_last <= issue_last;
            if (start_ok) begin
                mem_addr <= base_addr;
                len_q    <= len;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (issue) begin
                    mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + ADDR_ONE;
                    issued   <= issued + CNT_ONE;
                end
                if (beat_acc) begin
                    accepted <= accepted + CNT_ONE;
                end
            end
        end
    end

    stream_skid_fifo #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (in_flight),
        .wr_data  ({in_flight_last, mem_rd_data}),
        .rd_en    (m_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_out),
        .count    (fifo_count)
    );

    // Stream outputs come straight from the FIFO head; last is masked so it
    // never shows on an empty FIFO.
    always_comb begin
        mem_we  = 1'b0;
        m_valid = fifo_valid;
        m_data  = fifo_out[WIDTH-1:0];
        m_last  = fifo_valid && fifo_out[WIDTH];
    end

`ifdef MEM_STREAM_CHK_EN
    // Running XOR of accepted beats; holds its final value until the next
    // accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk <= '0;
        end else if (start_ok) begin
            chk <= '0;
        end else if (beat_acc) begin
            chk <= chk ^ m_data;
        end
    end
`endif

endmodule
